// File: rtl/cache_req_issue.sv
// Request issue queue between a CGRA load/store agent and the cache_l1 agent port.
// Optional watchdog/retry is built when CACHE_REQ_TIMEOUT_EN is defined.
module cache_req_issue #(
   parameter int ADDR_WDT    = 32,
   parameter int DATA_WDT    = 64,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_req_valid,
   output logic                     in_req_ready,
   input  logic [ADDR_WDT-1:0]      in_req_addr,
   input  logic                     in_req_wr,
   input  logic [DATA_WDT-1:0]      in_req_wr_data,
   output logic                     agent_req_en,
   output logic [ADDR_WDT-1:0]      agent_req_addr,
   output logic                     agent_req_wr,
   output logic [DATA_WDT-1:0]      agent_req_wr_data,
   input  logic                     agent_req_block,
   input  logic                     agent_req_done,
   input  logic [DATA_WDT-1:0]      agent_req_data,
   output logic                     rsp_valid,
   output logic                     rsp_wr,
   output logic [DATA_WDT-1:0]      rsp_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     err_timeout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WDT-1:0]   fifo_addr_q  [DEPTH];
   logic [ADDR_WDT-1:0]   fifo_addr_d  [DEPTH];
   logic                  fifo_wr_q    [DEPTH];
   logic                  fifo_wr_d    [DEPTH];
   logic [DATA_WDT-1:0]   fifo_data_q  [DEPTH];
   logic [DATA_WDT-1:0]   fifo_data_d  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  req_en_q, req_en_d;
   logic [ADDR_WDT-1:0]   req_addr_q, req_addr_d;
   logic                  req_wr_q, req_wr_d;
   logic [DATA_WDT-1:0]   req_data_q, req_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_wr_q, rsp_wr_d;
   logic [DATA_WDT-1:0]   rsp_data_q, rsp_data_d;
   logic                  push;
   logic                  pop;

`ifdef CACHE_REQ_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
`else
   logic [31:0]           unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
`endif

   // Ready depends only on the registered level, so a same-cycle pop never frees a full queue.
   assign in_req_ready = (level_q != LVL_W'(DEPTH));
   assign push         = in_req_valid && in_req_ready;

   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_wr_d   = fifo_wr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = in_req_addr;
         fifo_wr_d[wr_ptr_q]   = in_req_wr;
         fifo_data_d[wr_ptr_q] = in_req_wr_data;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_en_d    = 1'b0;
      req_addr_d  = req_addr_q;
      req_wr_d    = req_wr_q;
      req_data_d  = req_data_q;
      rsp_valid_d = 1'b0;
      rsp_wr_d    = 1'b0;
      rsp_data_d  = '0;
      pop         = 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if ((level_q != '0) && !agent_req_block) begin
               req_en_d   = 1'b1;
               req_addr_d = fifo_addr_q[rd_ptr_q];
               req_wr_d   = fifo_wr_q[rd_ptr_q];
               req_data_d = fifo_data_q[rd_ptr_q];
               state_d    = ST_WAIT;
`ifdef CACHE_REQ_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (agent_req_done) begin
               pop         = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_wr_d    = req_wr_q;
               rsp_data_d  = req_wr_q ? '0 : agent_req_data;
               state_d     = ST_IDLE;
            end
`ifdef CACHE_REQ_TIMEOUT_EN
            // Counter holds waited cycles minus one, so the retry lands TIMEOUT_CYC cycles after an issue.
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d    = 1'b1;
               req_en_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Queue storage carries no reset; only the pointers and level define its contents.
   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         req_en_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wr_q    <= 1'b0;
         req_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_data_q  <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         req_en_q    <= req_en_d;
         req_addr_q  <= req_addr_d;
         req_wr_q    <= req_wr_d;
         req_data_q  <= req_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_data_q  <= rsp_data_d;
`ifdef CACHE_REQ_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign agent_req_en      = req_en_q;
   assign agent_req_addr    = req_addr_q;
   assign agent_req_wr      = req_wr_q;
   assign agent_req_wr_data = req_data_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_wr            = rsp_wr_q;
   assign rsp_data          = rsp_data_q;
   assign fifo_level        = level_q;
`ifdef CACHE_REQ_TIMEOUT_EN
   assign err_timeout       = err_q;
`else
   assign err_timeout       = 1'b0;
`endif

endmodule
